// File: rtl/video_timing_pkg.sv
// Default timing presets for the two video modes, shared by the sync
// generator and anything that needs to agree with its geometry.
package video_timing_pkg;

  localparam int A_H_TOTAL    = 448;
  localparam int A_V_TOTAL    = 320;
  localparam int B_H_TOTAL    = 456;
  localparam int B_V_TOTAL    = 311;
  localparam int DEF_HS_START = 320;
  localparam int DEF_HS_LEN   = 32;
  localparam int DEF_VS_START = 248;
  localparam int DEF_VS_LEN   = 8;
  localparam int DEF_H_ACTIVE = 256;
  localparam int DEF_V_ACTIVE = 192;

  typedef enum logic {
    MODE_A = 1'b0,
    MODE_B = 1'b1
  } mode_e;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/video_axis_cnt.sv
// Wrap-and-carry counter for one raster axis; wrap doubles as the carry
// into the next axis.
module video_axis_cnt #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    wrap  = en && (cnt_q == last);
    cnt_d = cnt_q;
    if (wrap) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/video_sync_gen.sv
// Raster timing generator: pixel divider, h/v counters, registered sync,
// blanking and line/frame start strobes with a frame-aligned mode switch.
module video_sync_gen
  import video_timing_pkg::*;
#(
  parameter int HC_W      = 9,
  parameter int VC_W      = 9,
  parameter int DIV       = 2,
  parameter int H_TOTAL_A = A_H_TOTAL,
  parameter int V_TOTAL_A = A_V_TOTAL,
  parameter int H_TOTAL_B = B_H_TOTAL,
  parameter int V_TOTAL_B = B_V_TOTAL,
  parameter int HS_START  = DEF_HS_START,
  parameter int HS_LEN    = DEF_HS_LEN,
  parameter int VS_START  = DEF_VS_START,
  parameter int VS_LEN    = DEF_VS_LEN,
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int CS_BIT    = 3
) (
  input  logic            F14,
  input  logic            rst_n,
  input  logic            mode,
  input  logic            sync_inv,
  output logic [HC_W-1:0] hc,
  output logic [VC_W-1:0] vc,
  output logic            ce,
  output logic            hsync,
  output logic            vsync,
  output logic            csync,
  output logic            blank,
  output logic            line_start,
  output logic            frame_start,
  output logic            mode_active
);

  if (DIV < 1) begin : g_bad_div
    $error("video_sync_gen: DIV must be at least 1");
  end
  if (H_TOTAL_A > 2**HC_W || H_TOTAL_B > 2**HC_W) begin : g_bad_htotal
    $error("video_sync_gen: H_TOTAL does not fit in HC_W bits");
  end
  if (V_TOTAL_A > 2**VC_W || V_TOTAL_B > 2**VC_W) begin : g_bad_vtotal
    $error("video_sync_gen: V_TOTAL does not fit in VC_W bits");
  end
  if (HS_START + HS_LEN >= min_int(H_TOTAL_A, H_TOTAL_B)) begin : g_bad_hs
    $error("video_sync_gen: hsync window exceeds the shorter line");
  end
  if (VS_START + VS_LEN >= min_int(V_TOTAL_A, V_TOTAL_B)) begin : g_bad_vs
    $error("video_sync_gen: vsync window exceeds the shorter frame");
  end
  if (CS_BIT >= HC_W) begin : g_bad_csbit
    $error("video_sync_gen: CS_BIT outside the horizontal counter");
  end

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [HC_W-1:0]  H_LAST_A = HC_W'(H_TOTAL_A - 1);
  localparam logic [HC_W-1:0]  H_LAST_B = HC_W'(H_TOTAL_B - 1);
  localparam logic [VC_W-1:0]  V_LAST_A = VC_W'(V_TOTAL_A - 1);
  localparam logic [VC_W-1:0]  V_LAST_B = VC_W'(V_TOTAL_B - 1);
  localparam logic [HC_W-1:0]  HS_LO    = HC_W'(HS_START);
  localparam logic [HC_W-1:0]  HS_HI    = HC_W'(HS_START + HS_LEN);
  localparam logic [VC_W-1:0]  VS_LO    = VC_W'(VS_START);
  localparam logic [VC_W-1:0]  VS_HI    = VC_W'(VS_START + VS_LEN);
  localparam logic [HC_W:0]    H_ACT    = (HC_W+1)'(H_ACTIVE);
  localparam logic [VC_W:0]    V_ACT    = (VC_W+1)'(V_ACTIVE);

  logic [DIV_W-1:0] div_q, div_d;
  logic             run_q, run_d;
  logic             mode_active_q, mode_active_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             csync_q, csync_d;
  logic             blank_q, blank_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             ce_i, h_wrap, v_wrap, hs, vs;
  logic [HC_W-1:0]  hc_cnt, h_last;
  logic [VC_W-1:0]  vc_cnt, v_last;

  video_axis_cnt #(.W(HC_W)) u_hcnt (
    .clk  (F14),
    .rst_n(rst_n),
    .en   (ce_i),
    .last (h_last),
    .cnt  (hc_cnt),
    .wrap (h_wrap)
  );

  video_axis_cnt #(.W(VC_W)) u_vcnt (
    .clk  (F14),
    .rst_n(rst_n),
    .en   (h_wrap),
    .last (v_last),
    .cnt  (vc_cnt),
    .wrap (v_wrap)
  );

  // run_q holds ce low for the first cycle out of reset so ce reads 0 in reset even with DIV=1
  always_comb begin
    run_d         = 1'b1;
    ce_i          = run_q && (div_q == DIV_LAST);
    div_d         = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    h_last        = (mode_active_q == MODE_B) ? H_LAST_B : H_LAST_A;
    v_last        = (mode_active_q == MODE_B) ? V_LAST_B : V_LAST_A;
    hs            = (hc_cnt >= HS_LO) && (hc_cnt < HS_HI);
    vs            = (vc_cnt >= VS_LO) && (vc_cnt < VS_HI);
    mode_active_d = v_wrap ? mode : mode_active_q;
    hsync_d       = hs ^ sync_inv;
    vsync_d       = vs ^ sync_inv;
    csync_d       = hc_cnt[CS_BIT] ? (~(hs ^ vs) ^ sync_inv) : csync_q;
    blank_d       = ({1'b0, hc_cnt} >= H_ACT) || ({1'b0, vc_cnt} >= V_ACT);
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
  end

  always_ff @(posedge F14) begin
    if (!rst_n) begin
      div_q         <= '0;
      run_q         <= 1'b0;
      mode_active_q <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      csync_q       <= 1'b1;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      run_q         <= run_d;
      mode_active_q <= mode_active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      csync_q       <= csync_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hc          = hc_cnt;
  assign vc          = vc_cnt;
  assign ce          = ce_i;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign csync       = csync_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign mode_active = mode_active_q;

endmodule

// File: tb/tb_video_sync_gen.sv
// Directed bench for video_sync_gen: full-width lines with a shortened frame,
// plus a second instance with sync_inv=1 compared cycle by cycle.
module tb_video_sync_gen;

  localparam int HC_W = 9;
  localparam int VC_W = 4;

  logic            F14 = 1'b0;
  logic            rst_n;
  logic            mode;
  logic [HC_W-1:0] hc, hc_i;
  logic [VC_W-1:0] vc, vc_i;
  logic            ce, ce_i, hsync, hsync_i, vsync, vsync_i, csync, csync_i;
  logic            blank, blank_i, line_start, line_start_i;
  logic            frame_start, frame_start_i, mode_active, mode_active_i;

  int checks   = 0;
  int failures = 0;
  int inv_bad  = 0;
  bit inv_on   = 1'b0;

  always #5 F14 = ~F14;

  video_sync_gen #(
    .HC_W(HC_W), .VC_W(VC_W), .DIV(2),
    .H_TOTAL_A(448), .V_TOTAL_A(12), .H_TOTAL_B(456), .V_TOTAL_B(10),
    .HS_START(320), .HS_LEN(32), .VS_START(6), .VS_LEN(2),
    .H_ACTIVE(256), .V_ACTIVE(4), .CS_BIT(3)
  ) u_dut (
    .F14(F14), .rst_n(rst_n), .mode(mode), .sync_inv(1'b0),
    .hc(hc), .vc(vc), .ce(ce), .hsync(hsync), .vsync(vsync), .csync(csync),
    .blank(blank), .line_start(line_start), .frame_start(frame_start),
    .mode_active(mode_active)
  );

  video_sync_gen #(
    .HC_W(HC_W), .VC_W(VC_W), .DIV(2),
    .H_TOTAL_A(448), .V_TOTAL_A(12), .H_TOTAL_B(456), .V_TOTAL_B(10),
    .HS_START(320), .HS_LEN(32), .VS_START(6), .VS_LEN(2),
    .H_ACTIVE(256), .V_ACTIVE(4), .CS_BIT(3)
  ) u_inv (
    .F14(F14), .rst_n(rst_n), .mode(mode), .sync_inv(1'b1),
    .hc(hc_i), .vc(vc_i), .ce(ce_i), .hsync(hsync_i), .vsync(vsync_i), .csync(csync_i),
    .blank(blank_i), .line_start(line_start_i), .frame_start(frame_start_i),
    .mode_active(mode_active_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge F14);
    if (inv_on) begin
      if (hsync_i !== ~hsync || vsync_i !== ~vsync || csync_i !== ~csync ||
          hc_i !== hc || vc_i !== vc || blank_i !== blank || ce_i !== ce ||
          line_start_i !== line_start || frame_start_i !== frame_start ||
          mode_active_i !== mode_active)
        inv_bad++;
    end
  endtask

  task automatic wait_line_start(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!line_start && n < 2000);
  endtask

  task automatic measure_line(output int n, output int hs_n, output int cs_low,
                              output int cs_fall_hc, output int cs_rise_hc,
                              output int bl_n, output int ce_n);
    n = 0; hs_n = 0; cs_low = 0; bl_n = 0; ce_n = 0;
    cs_fall_hc = -1; cs_rise_hc = -1;
    do begin
      step();
      n++;
      hs_n += int'(hsync);
      bl_n += int'(blank);
      ce_n += int'(ce);
      if (!csync) begin
        cs_low++;
        if (cs_fall_hc < 0) cs_fall_hc = int'(hc);
      end else if (cs_fall_hc >= 0 && cs_rise_hc < 0) begin
        cs_rise_hc = int'(hc);
      end
    end while (!line_start && n < 2000);
  endtask

  task automatic measure_frame(input int mode_at_vc, input logic exp_ma,
                               output int n, output int ls_n, output int vs_n,
                               output int hc_max, output int vc_max, output int ma_bad);
    n = 0; ls_n = 0; vs_n = 0; hc_max = 0; vc_max = 0; ma_bad = 0;
    do begin
      step();
      n++;
      ls_n += int'(line_start);
      vs_n += int'(vsync);
      if (int'(hc) > hc_max) hc_max = int'(hc);
      if (int'(vc) > vc_max) vc_max = int'(vc);
      if (mode_at_vc >= 0 && int'(vc) == mode_at_vc) mode = 1'b1;
      if (!frame_start && mode_active !== exp_ma) ma_bad++;
    end while (!frame_start && n < 20000);
  endtask

  initial begin
    int n, hs_n, cs_low, cs_fall, cs_rise, bl_n, ce_n;
    int ls_n, vs_n, hc_max, vc_max, ma_bad;

    rst_n = 1'b0;
    mode  = 1'b0;
    repeat (3) step();
    chk("rst_hc", 32'(hc), 0);
    chk("rst_vc", 32'(vc), 0);
    chk("rst_csync", 32'(csync), 1);
    chk("rst_hsync", 32'(hsync), 0);
    chk("rst_vsync", 32'(vsync), 0);
    chk("rst_blank", 32'(blank), 0);
    chk("rst_line_start", 32'(line_start), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_ce", 32'(ce), 0);
    chk("rst_mode_active", 32'(mode_active), 0);
    chk("rst_inv_csync", 32'(csync_i), 1);
    chk("rst_inv_hsync", 32'(hsync_i), 0);

    rst_n = 1'b1;
    step();
    chk("rel_hc", 32'(hc), 0);
    chk("rel_vc", 32'(vc), 0);
    chk("rel_ce", 32'(ce), 1);

    wait_line_start(n);
    chk("first_line_cycles", n, 895);
    chk("first_line_vc", 32'(vc), 1);
    chk("first_line_hc", 32'(hc), 0);
    chk("first_line_no_fs", 32'(frame_start), 0);

    // Mode A line at vc=1: outside vsync, inside vertical active area
    inv_on = 1'b1;
    measure_line(n, hs_n, cs_low, cs_fall, cs_rise, bl_n, ce_n);
    chk("lineA_cycles", n, 896);
    chk("lineA_hsync_high", hs_n, 64);
    chk("lineA_csync_low", cs_low, 64);
    chk("lineA_csync_fall_hc", cs_fall, 328);
    chk("lineA_csync_rise_hc", cs_rise, 360);
    chk("lineA_blank", bl_n, 384);
    chk("lineA_ce", ce_n, 448);
    chk("lineA_next_vc", 32'(vc), 2);

    n = 0;
    do begin
      step();
      n++;
    end while (!frame_start && n < 12000);
    chk("fs_seen", 32'(frame_start), 1);
    chk("fs_cycles_from_vc2", n, 8960);
    chk("fs_with_ls", 32'(line_start), 1);
    chk("fs_hc", 32'(hc), 0);
    chk("fs_vc", 32'(vc), 0);
    chk("fs_mode_active", 32'(mode_active), 0);

    // Request mode B at vc=3; this frame must still run with mode A geometry
    measure_frame(3, 1'b0, n, ls_n, vs_n, hc_max, vc_max, ma_bad);
    chk("frameA_cycles", n, 10752);
    chk("frameA_line_starts", ls_n, 12);
    chk("frameA_vsync_high", vs_n, 1792);
    chk("frameA_hc_max", hc_max, 447);
    chk("frameA_vc_max", vc_max, 11);
    chk("frameA_mode_held", ma_bad, 0);
    chk("frameA_end_fs_with_ls", 32'(line_start), 1);
    chk("frameB_mode_active", 32'(mode_active), 1);

    measure_frame(-1, 1'b1, n, ls_n, vs_n, hc_max, vc_max, ma_bad);
    chk("frameB_cycles", n, 9120);
    chk("frameB_line_starts", ls_n, 10);
    chk("frameB_vsync_high", vs_n, 1824);
    chk("frameB_hc_max", hc_max, 455);
    chk("frameB_vc_max", vc_max, 9);
    chk("frameB_mode_held", ma_bad, 0);
    chk("inv_mismatch_cycles", inv_bad, 0);
    inv_on = 1'b0;

    // Reset lands on the very edge that would wrap the line at vc=7
    n = 0;
    do begin
      step();
      n++;
    end while (!(vc == 4'd7 && hc == 9'd455 && ce) && n < 10000);
    chk("mid_wrap_point_seen", 32'(vc), 7);
    rst_n = 1'b0;
    step();
    chk("mid_rst_hc", 32'(hc), 0);
    chk("mid_rst_vc", 32'(vc), 0);
    chk("mid_rst_line_start", 32'(line_start), 0);
    chk("mid_rst_frame_start", 32'(frame_start), 0);
    chk("mid_rst_vsync", 32'(vsync), 0);
    chk("mid_rst_csync", 32'(csync), 1);
    chk("mid_rst_mode_active", 32'(mode_active), 0);
    rst_n = 1'b1;
    step();
    chk("mid_rel_hc", 32'(hc), 0);
    chk("mid_rel_vc", 32'(vc), 0);
    chk("mid_rel_line_start", 32'(line_start), 0);
    wait_line_start(n);
    chk("mid_first_line_cycles", n, 895);
    chk("mid_first_line_vc", 32'(vc), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
